kypd_scan_ctrl: RTL and testbench
=================================

// Module: kypd_scan_ctrl
// PURPOSE
//  Scan controller for the PmodKYPD 4x4 keypad: drives one column low at a time,
//  samples the rows and debounces across whole scan frames. Emits a stable key code
//  plus press/release strobes for the display and speaker logic.
//  Sits between the keypad Pmod pins (JC) and the key-consumer blocks.
// PARAMETERS
//  SCAN_DIV        100000  clk cycles per column phase (1 ms at 100 MHz); must be >= 2
//  DEBOUNCE_SCANS  4       consecutive identical frame results needed to commit; must be >= 1
// PORTS
//  clk          in   1  100 MHz system clock
//  rst          in   1  asynchronous reset, active high
//  col          out  4  column drive, active low, exactly one bit low (JC[3:0])
//  row          in   4  row sense, active low, externally pulled up (JC[7:4])
//  key_code     out  4  hex code of committed key
//  key_valid    out  1  high while a single key is committed as held
//  key_press    out  1  1-cycle pulse; key_code is valid in the same cycle
//  key_release  out  1  1-cycle pulse when the committed key is released
//  multi        out  1  high while the committed frame result is >1 key pressed
// BEHAVIOUR
//  Reset: col=4'b0111, phase=0, divider=0, key_code=0, key_valid/key_press/key_release/multi=0,
//    stable count=0, previous frame result=NONE, FSM=IDLE. Reset mid-scan aborts the frame.
//  Key map (row\col): row[3]: col[3]=1, col[2]=2, col[1]=3, col[0]=A
//    row[2]: 4 5 6 B | row[1]: 7 8 9 C | row[0]: 0 F E D
//  Scan: phases 0..3 drive col[3],col[2],col[1],col[0] low in turn.
//    Each phase lasts SCAN_DIV cycles. Rows are sampled only on the last cycle of a phase
//    (settling time), then col advances and phase wraps 3->0.
//  Frame result, evaluated after the phase-3 sample: NONE (0 lows), ONE(code) (exactly 1 low
//    across all 16 positions), MULTI (>=2 lows). Per-frame low count saturates at 2.
//  Debounce: if result==previous, stable count increments (saturating at DEBOUNCE_SCANS),
//    else count=1. Commit fires once, on the frame where the count first reaches
//    DEBOUNCE_SCANS. With DEBOUNCE_SCANS=1, every change of result commits.
//  FSM IDLE:
//    commit ONE(c) -> PRESSED; key_code=c, key_valid=1, key_press pulse (same cycle as update).
//    commit MULTI -> stay IDLE, multi=1.
//    commit NONE -> multi=0.
//  FSM PRESSED:
//    commit NONE -> IDLE; key_valid=0, key_release pulse; key_code holds last value; multi=0.
//    commit ONE(c'), c'!=key_code -> key_release pulse in the commit cycle; on the next cycle
//      key_code=c', key_press pulse; key_valid stays 1 throughout.
//    commit MULTI -> stay PRESSED (roll-over hold), multi=1; no pulses.
//    commit ONE(same) -> multi=0 only.
//  key_press and key_release are never high in the same cycle.
//  Latency: a clean press is committed DEBOUNCE_SCANS frames after the first frame that
//    sees it; the pulse arrives 1 cycle after the final phase-3 sample.
//  Widths: divider is $clog2(SCAN_DIV) bits, wraps at SCAN_DIV-1; stable counter is
//    $clog2(DEBOUNCE_SCANS+1) bits.
//  All outputs are registered.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3; frame = 16 cycles)
//  Reset, no keys -> col cycles 0111,1011,1101,1110 every 4 clk; no pulses; key_valid=0.
//  Hold '5' (row[2] low while col[2] low) for 5 frames -> key_press after frame 3 with
//    key_code=5, key_valid=1; release -> key_release 3 frames later, key_valid=0.
//  Bounce '9' on/off in alternate frames for 8 frames -> no key_press, no key_release.
//  Hold 'A' then add 'D' -> multi=1, key_code stays A, key_valid=1; release D -> multi=0,
//    no pulses.
//  Held '1' changes to '0' -> key_release then key_press next cycle, key_code=0.
//  Assert rst mid-phase while key_valid=1 -> all outputs 0, col=0111 immediately (async).

Source files
------------

// File: rtl/kypd_scan_ctrl.sv
// PmodKYPD 4x4 keypad scanner: walks a low column across the pad, tallies row lows
// per frame, debounces whole frames and emits a committed key code with press/release strobes.
module kypd_scan_ctrl #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release,
  output logic       multi
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} res_t;
  typedef enum logic [1:0] {IDLE, PRESSED, SWAP} state_t;

  logic [DIV_W-1:0] div;
  logic [1:0]       phase;
  logic [1:0]       low_cnt;
  logic [3:0]       acc_code;
  res_t             prev_kind;
  logic [3:0]       prev_code;
  logic [CNT_W-1:0] stable_cnt;
  state_t           state, state_n;

  logic [2:0]       phase_lows;
  logic [1:0]       phase_row;
  logic [2:0]       lows_sum;
  logic [1:0]       frame_lows;
  logic [3:0]       frame_code;
  res_t             frame_kind;
  logic             sample, frame_end, same, commit;
  logic [CNT_W-1:0] cnt_next;

  logic [3:0] key_code_n;
  logic       key_valid_n, key_press_n, key_release_n, multi_n;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'hD;  4'h1: k = 4'hE;  4'h2: k = 4'hF;  4'h3: k = 4'h0;
      4'h4: k = 4'hC;  4'h5: k = 4'h9;  4'h6: k = 4'h8;  4'h7: k = 4'h7;
      4'h8: k = 4'hB;  4'h9: k = 4'h6;  4'hA: k = 4'h5;  4'hB: k = 4'h4;
      4'hC: k = 4'hA;  4'hD: k = 4'h3;  4'hE: k = 4'h2;  default: k = 4'h1;
    endcase
    return k;
  endfunction

  // Fold this phase's row lows into the running frame tally; the code is only kept
  // while the frame has seen exactly one low so far.
  always_comb begin
    phase_lows = '0;
    phase_row  = '0;
    for (int i = 0; i < 4; i++) begin
      if (!row[i]) begin
        phase_lows = phase_lows + 3'd1;
        phase_row  = 2'(i);
      end
    end
    lows_sum   = {1'b0, low_cnt} + phase_lows;
    frame_lows = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
    frame_code = (low_cnt == 2'd0 && phase_lows == 3'd1) ? key_map(phase_row, 2'd3 - phase)
                                                         : acc_code;
    frame_kind = (frame_lows == 2'd0) ? RES_NONE : (frame_lows == 2'd1) ? RES_ONE : RES_MULTI;
    sample     = (div == DIV_LAST);
    frame_end  = sample && (phase == 2'd3);
    same       = (frame_kind == prev_kind) && (frame_kind != RES_ONE || frame_code == prev_code);
    cnt_next   = same ? ((stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1))
                      : CNT_W'(1);
    commit     = frame_end && (cnt_next == CNT_MAX) && (!same || stable_cnt != CNT_MAX);
  end

  // Column scan and per-frame debounce bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      phase      <= 2'd0;
      col        <= 4'b0111;
      low_cnt    <= 2'd0;
      acc_code   <= 4'd0;
      prev_kind  <= RES_NONE;
      prev_code  <= 4'd0;
      stable_cnt <= '0;
    end else if (sample) begin
      div   <= '0;
      phase <= phase + 2'd1;
      col   <= {col[0], col[3:1]};
      if (frame_end) begin
        low_cnt    <= 2'd0;
        acc_code   <= 4'd0;
        prev_kind  <= frame_kind;
        prev_code  <= frame_code;
        stable_cnt <= cnt_next;
      end else begin
        low_cnt  <= frame_lows;
        acc_code <= frame_code;
      end
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi       <= 1'b0;
    end else begin
      state       <= state_n;
      key_code    <= key_code_n;
      key_valid   <= key_valid_n;
      key_press   <= key_press_n;
      key_release <= key_release_n;
      multi       <= multi_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (commit && frame_kind == RES_ONE) state_n = PRESSED;
      PRESSED: begin
        if (commit && frame_kind == RES_NONE) state_n = IDLE;
        else if (commit && frame_kind == RES_ONE && frame_code != key_code) state_n = SWAP;
      end
      SWAP:    state_n = PRESSED;
      default: state_n = IDLE;
    endcase
  end

  // SWAP emits the press half of a key change; the new code already sits in prev_code.
  always_comb begin
    key_code_n    = key_code;
    key_valid_n   = key_valid;
    key_press_n   = 1'b0;
    key_release_n = 1'b0;
    multi_n       = commit ? (frame_kind == RES_MULTI) : multi;
    case (state)
      IDLE: begin
        if (commit && frame_kind == RES_ONE) begin
          key_code_n  = frame_code;
          key_valid_n = 1'b1;
          key_press_n = 1'b1;
        end
      end
      PRESSED: begin
        if (commit && frame_kind == RES_NONE) begin
          key_valid_n   = 1'b0;
          key_release_n = 1'b1;
        end else if (commit && frame_kind == RES_ONE && frame_code != key_code) begin
          key_release_n = 1'b1;
        end
      end
      SWAP: begin
        key_code_n  = prev_code;
        key_press_n = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Bench for kypd_scan_ctrl: a keypad model drives rows from held keys; a frame-level
// model predicts every output cycle by cycle, alongside a table of scripted steps.
module tb_kypd_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col, row, key_code;
  logic       key_valid, key_press, key_release, multi;
  logic [15:0] mask = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  // Key code at position r*4+c of the pad
  int keymap[16] = '{13, 14, 15, 0, 12, 9, 8, 7, 11, 6, 5, 4, 10, 3, 2, 1};

  int hist[$];
  int m_valid, m_multi, m_code, code_j0, p_press0, p_rel0, p_press1;
  int press_seen, rel_seen;

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          exp_valid;
    int          exp_code;
    int          exp_multi;
    int          exp_press;
    int          exp_rel;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  kypd_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_press(key_press), .key_release(key_release), .multi(multi)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_valid = 0; m_multi = 0; m_code = 0; code_j0 = 0;
    p_press0 = 0; p_rel0 = 0; p_press1 = 0;
  endtask

  // -1 = no key, 16 = several keys, otherwise the single key's code
  function automatic int frame_result(input logic [15:0] m);
    int n = $countones(m);
    if (n == 0) return -1;
    if (n >= 2) return 16;
    for (int p = 0; p < 16; p++) if (m[p]) return keymap[p];
    return -1;
  endfunction

  task automatic model_frame(input logic [15:0] m);
    int r, run;
    r = frame_result(m);
    hist.push_back(r);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != r) break;
      run++;
    end
    p_press0 = 0; p_rel0 = 0; p_press1 = 0;
    code_j0 = m_code;
    if (run == DEB) begin
      if (m_valid == 0) begin
        if (r >= 0 && r < 16) begin
          m_valid = 1; m_code = r; code_j0 = r; p_press0 = 1; m_multi = 0;
        end else begin
          m_multi = (r == 16) ? 1 : 0;
        end
      end else if (r < 0) begin
        m_valid = 0; p_rel0 = 1; m_multi = 0;
      end else if (r == 16) begin
        m_multi = 1;
      end else begin
        m_multi = 0;
        if (r != m_code) begin
          p_rel0 = 1; p_press1 = 1; code_j0 = m_code; m_code = r;
        end
      end
    end
  endtask

  // Called at a negedge in the first cycle of a frame; returns at the next frame's first negedge.
  task automatic applyStimulus(input logic [15:0] m);
    logic [3:0] ec;
    mask = m;
    for (int j = 0; j < FRAME; j++) begin
      ec = ~(4'b1000 >> (j / SCAN_DIV));
      checkOutput("col", col, ec);
      checkOutput("key_press", key_press, (j == 0) ? p_press0 : ((j == 1) ? p_press1 : 0));
      checkOutput("key_release", key_release, (j == 0) ? p_rel0 : 0);
      checkOutput("key_valid", key_valid, m_valid);
      checkOutput("key_code", key_code, (j == 0) ? code_j0 : m_code);
      checkOutput("multi", multi, m_multi);
      if (key_press) press_seen++;
      if (key_release) rel_seen++;
      @(posedge clk);
      @(negedge clk);
    end
    model_frame(m);
  endtask

  initial begin
    logic [15:0] rm;
    int nf;

    vecs[0]  = '{16'h0000, 4, 0, 0,  0, 0, 0};
    vecs[1]  = '{16'h0400, 5, 1, 5,  0, 1, 0};
    vecs[2]  = '{16'h0000, 4, 0, 5,  0, 0, 1};
    for (int i = 3; i <= 10; i++)
      vecs[i] = '{((i % 2) == 1) ? 16'h0020 : 16'h0000, 1, 0, 5, 0, 0, 0};
    vecs[11] = '{16'h1000, 4, 1, 10, 0, 1, 0};
    vecs[12] = '{16'h1001, 4, 1, 10, 1, 0, 0};
    vecs[13] = '{16'h1000, 4, 1, 10, 0, 0, 0};
    vecs[14] = '{16'h8000, 4, 1, 1,  0, 1, 1};
    vecs[15] = '{16'h0008, 4, 1, 0,  0, 1, 1};
    vecs[16] = '{16'h0000, 4, 0, 0,  0, 0, 1};

    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 17; v++) begin
      press_seen = 0;
      rel_seen = 0;
      for (int f = 0; f < vecs[v].frames; f++) applyStimulus(vecs[v].mask);
      checkOutput($sformatf("step%0d_valid", v), key_valid, vecs[v].exp_valid);
      checkOutput($sformatf("step%0d_code", v), key_code, vecs[v].exp_code);
      checkOutput($sformatf("step%0d_multi", v), multi, vecs[v].exp_multi);
      checkOutput($sformatf("step%0d_presses", v), press_seen, vecs[v].exp_press);
      checkOutput($sformatf("step%0d_releases", v), rel_seen, vecs[v].exp_rel);
    end

    // Async reset in the middle of a phase while '2' is held
    for (int f = 0; f < 4; f++) applyStimulus(16'h4000);
    checkOutput("valid_before_reset", key_valid, 1);
    checkOutput("code_before_reset", key_code, 2);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_col", col, 4'b0111);
    checkOutput("rst_valid", key_valid, 0);
    checkOutput("rst_code", key_code, 0);
    checkOutput("rst_press", key_press, 0);
    checkOutput("rst_release", key_release, 0);
    checkOutput("rst_multi", multi, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mask = 16'h0000;
    model_reset();
    for (int f = 0; f < 4; f++) applyStimulus(16'h0000);

    // Randomized key activity checked cycle by cycle against the frame model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    rm = 16'h0000;
        8, 9:       rm = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default:    rm = 16'h0001 << $urandom_range(0, 15);
      endcase
      nf = $urandom_range(1, 5);
      for (int f = 0; f < nf; f++) applyStimulus(rm);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
